compress_sched: RTL and testbench
=================================

COMPRESS_SCHED -- requirements
Module: compress_sched

Interface
REQ-001 Parameter: CMP_LAT, default 2, cycles from cmp_start high to cmp_lines/cmp_flag valid (range 1..15).
REQ-002 Port: clk  in  1  sole clock, all state rising-edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  2  per-requester block-available flag.
REQ-005 Port: req_pixels0 / req_pixels1  in  types::pixels_t (1024)  32-pixel RGBA block from requester 0 / 1.
REQ-006 Port: req_ready  out  2  per-requester accept, one-hot or zero.
REQ-007 Port: cmp_pixels  out  types::pixels_t  block presented to the compressor datapath.
REQ-008 Port: cmp_start  out  1  one-cycle launch pulse to the compressor.
REQ-009 Port: cmp_lines  in  [1:0][511:0]  compressor output lines.
REQ-010 Port: cmp_flag  in  2  compressor result code.
REQ-011 Port: out_valid / out_ready  out / in  1 / 1  output line handshake.
REQ-012 Port: out_line  out  512  emitted line.
REQ-013 Port: out_last  out  1  marks final line of a block.
REQ-014 Port: out_flag  out  2  cmp_flag of the block being emitted.
REQ-015 Port: out_src  out  1  requester index of the block being emitted.
REQ-016 Port: err  out  1  one-cycle pulse on reserved flag code.
REQ-017 Port: busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT, SEND0, SEND1.
REQ-019 req_ready SHALL be nonzero only in IDLE, combinationally from req_valid and the priority pointer.
REQ-020 Arbitration: round-robin; if both valid, grant index = prio; if one valid, grant it; after each accept prio <= ~granted index.
REQ-021 Accept (req_valid[i] & req_ready[i]) in cycle T SHALL load the holding register with req_pixelsi, latch src=i, go to LAUNCH.
REQ-022 cmp_pixels SHALL equal the holding register at all times; the register SHALL not change from accept until the block's out_last handshake.
REQ-023 cmp_start SHALL be 1 exactly in LAUNCH (cycle T+1); LAUNCH -> WAIT with down-counter loaded to CMP_LAT-1.
REQ-024 WAIT: counter decrements each cycle; at zero (cycle T+1+CMP_LAT) cmp_lines/cmp_flag SHALL be captured into result registers and FSM -> SEND0.
REQ-025 Flag 2'b01: emit one line = lines[0]; SEND0 has out_last=1.
REQ-026 Flag 2'b10: emit lines[0] in SEND0, lines[1] in SEND1 (out_last=1 in SEND1 only).
REQ-027 Flag 2'b00 (raw fallback): emit holding[1023:512] in SEND0, holding[511:0] in SEND1, out_last in SEND1.
REQ-028 Flag 2'b11: treated as 2'b10 for emission; err SHALL pulse one cycle at capture.
REQ-029 out_valid SHALL be 1 in SEND0/SEND1 only; out_line/out_last/out_flag/out_src stable while out_valid & ~out_ready.
REQ-030 SEND state advances only on out_ready; after last-line handshake FSM -> IDLE, where a new accept MAY occur the next cycle.
REQ-031 Minimum block period with out_ready tied high: CMP_LAT+3 cycles (one-line) or CMP_LAT+4 (two-line).
REQ-032 req_valid changes during non-IDLE states SHALL have no effect.

Reset
REQ-033 rst high at a clock edge SHALL force IDLE, prio=0, counter=0, result and holding registers=0, from any state including mid-WAIT/SEND.
REQ-034 During and after reset until an accept: req_ready=0 unless IDLE with req_valid, cmp_start=0, out_valid=0, out_last=0, out_flag=0, out_src=0, err=0, busy=0; cmp_pixels=0.
REQ-035 A block in flight at reset SHALL be dropped with no out_valid emitted for it.

Verification
REQ-036 Both req_valid=1 after reset, out_ready=1, cmp_flag=01 -> req_ready=01 first, then 10 next block; out_src 0 then 1.
REQ-037 Accept at cycle T, CMP_LAT=2 -> cmp_start high only at T+1; out_valid first at T+4 with out_line=cmp_lines[0], out_last=1.
REQ-038 cmp_flag=00, pixels r_channel[0]=0xAB -> two lines equal to pixel block upper/lower 512 bits, out_flag=00, out_last on second only.
REQ-039 cmp_flag=10, out_ready low 5 cycles in SEND0 -> out_line/out_last held constant; lines[1] follows one cycle after out_ready rises.
REQ-040 cmp_flag=11 -> err pulses one cycle, two lines emitted as for 10.
REQ-041 rst asserted during WAIT -> next cycle IDLE, busy=0, out_valid never asserted for that block, next grant to requester 0.

Source files
------------

// File: rtl/compress_sched.sv
`default_nettype none
// ============================================================================
// Module   : compress_sched
// Function : Round-robin front end feeding a fixed-latency block compressor
//            and serialising its one- or two-line result onto a line stream.
// Revision : 1.0
// ============================================================================

package types;
    typedef struct packed {
        logic [31:0][7:0] r_channel;
        logic [31:0][7:0] g_channel;
        logic [31:0][7:0] b_channel;
        logic [31:0][7:0] a_channel;
    } pixels_t;
endpackage

module compress_sched #(
    parameter int CMP_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  types::pixels_t    req_pixels0,
    input  types::pixels_t    req_pixels1,
    output logic [1:0]        req_ready,
    output types::pixels_t    cmp_pixels,
    output logic              cmp_start,
    input  logic [1:0][511:0] cmp_lines,
    input  logic [1:0]        cmp_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [511:0]      out_line,
    output logic              out_last,
    output logic [1:0]        out_flag,
    output logic              out_src,
    output logic              err,
    output logic              busy
);

    localparam logic [3:0] c_lat_m1 = 4'(CMP_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_SEND0  = 3'd3,
        S_SEND1  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_prio;
    logic              r_src;
    logic [3:0]        r_cnt;
    types::pixels_t    r_hold;
    logic [1:0][511:0] r_lines;
    logic [1:0]        r_flag;

    logic w_grant_idx;
    logic w_accept;
    logic w_capture;

    // With both requesters pending the pointer decides; a lone requester always wins.
    always_comb begin
        w_grant_idx = r_prio;
        if (req_valid == 2'b01)
            w_grant_idx = 1'b0;
        else if (req_valid == 2'b10)
            w_grant_idx = 1'b1;
        w_accept  = (r_state == S_IDLE) && (|req_valid);
        req_ready = w_accept ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;
    end

    assign w_capture  = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign cmp_start  = (r_state == S_LAUNCH);
    assign cmp_pixels = r_hold;
    assign busy       = (r_state != S_IDLE);
    assign err        = w_capture && (cmp_flag == 2'b11);
    assign out_flag   = r_flag;
    assign out_src    = r_src;

    // Raw fallback (flag 00) sends the held block itself, upper half first.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_line  = '0;
        case (r_state)
            S_SEND0: begin
                out_valid = 1'b1;
                out_line  = (r_flag == 2'b00) ? r_hold[1023:512] : r_lines[0];
                out_last  = (r_flag == 2'b01);
            end
            S_SEND1: begin
                out_valid = 1'b1;
                out_line  = (r_flag == 2'b00) ? r_hold[511:0] : r_lines[1];
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_LAUNCH;
            S_LAUNCH: w_state_next = S_WAIT;
            S_WAIT:   if (w_capture) w_state_next = S_SEND0;
            S_SEND0:  if (out_ready) w_state_next = out_last ? S_IDLE : S_SEND1;
            S_SEND1:  if (out_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_src   <= 1'b0;
            r_cnt   <= 4'd0;
            r_hold  <= '0;
            r_lines <= '0;
            r_flag  <= 2'b00;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_hold <= w_grant_idx ? req_pixels1 : req_pixels0;
                r_src  <= w_grant_idx;
                r_prio <= ~w_grant_idx;
            end
            if (r_state == S_LAUNCH)
                r_cnt <= c_lat_m1;
            else if ((r_state == S_WAIT) && (r_cnt != 4'd0))
                r_cnt <= r_cnt - 4'd1;
            if (w_capture) begin
                r_lines <= cmp_lines;
                r_flag  <= cmp_flag;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_compress_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_compress_sched
// Function : Directed scoreboard bench for compress_sched.
// Revision : 1.0
// ============================================================================

module tb_compress_sched;

    localparam int CMP_LAT = 2;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    types::pixels_t    req_pixels0;
    types::pixels_t    req_pixels1;
    logic [1:0]        req_ready;
    types::pixels_t    cmp_pixels;
    logic              cmp_start;
    logic [1:0][511:0] cmp_lines;
    logic [1:0]        cmp_flag;
    logic              out_valid;
    logic              out_ready;
    logic [511:0]      out_line;
    logic              out_last;
    logic [1:0]        out_flag;
    logic              out_src;
    logic              err;
    logic              busy;

    compress_sched #(.CMP_LAT(CMP_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_pixels0(req_pixels0), .req_pixels1(req_pixels1),
        .req_ready(req_ready), .cmp_pixels(cmp_pixels), .cmp_start(cmp_start),
        .cmp_lines(cmp_lines), .cmp_flag(cmp_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_line(out_line),
        .out_last(out_last), .out_flag(out_flag), .out_src(out_src),
        .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] line;
        logic         last;
        logic [1:0]   flag;
        logic         src;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   err_cnt = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [511:0] line, input logic last, input logic [1:0] flag,
                        input logic src);
        exp_t e;
        e.line = line; e.last = last; e.flag = flag; e.src = src;
        sb.push_back(e);
    endtask

    // Monitor: every accepted output line is matched against the scoreboard head.
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_line: got %0h want none", out_line);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_line", out_line, e.line);
                chk("out_last", 512'(out_last), 512'(e.last));
                chk("out_flag", 512'(out_flag), 512'(e.flag));
                chk("out_src", 512'(out_src), 512'(e.src));
            end
        end
    end

    // Called at a negedge in IDLE; returns at a negedge in IDLE after the block.
    task automatic run_block(input logic [1:0] vmask, input logic exp_src, input logic [1:0] flag,
                             input logic [511:0] l0, input logic [511:0] l1,
                             input types::pixels_t pix0, input types::pixels_t pix1,
                             input int stall);
        types::pixels_t pix;
        logic [511:0]   held_line;
        int             t;
        int             errs0;
        req_valid    = vmask;
        req_pixels0  = pix0;
        req_pixels1  = pix1;
        cmp_flag     = flag;
        cmp_lines[0] = l0;
        cmp_lines[1] = l1;
        out_ready    = (stall == 0);
        #1;
        t = 0;
        while (req_ready == 2'b00 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("grant_timeout", 512'(1), 512'(0));
            return;
        end
        chk("req_ready", 512'(req_ready), exp_src ? 512'(2) : 512'(1));
        pix = exp_src ? pix1 : pix0;
        case (flag)
            2'b01: push(l0, 1'b1, flag, exp_src);
            2'b00: begin
                push(pix[1023:512], 1'b0, flag, exp_src);
                push(pix[511:0], 1'b1, flag, exp_src);
            end
            default: begin
                push(l0, 1'b0, flag, exp_src);
                push(l1, 1'b1, flag, exp_src);
            end
        endcase
        errs0 = err_cnt;
        for (int k = 1; k <= CMP_LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("cmp_start_launch", 512'(cmp_start), 512'(1));
                chk("cmp_pixels", 512'(cmp_pixels == pix), 512'(1));
                req_valid   = ~vmask;
                req_pixels0 = ~pix0;
                req_pixels1 = ~pix1;
            end
            if (k == 2) begin
                chk("cmp_start_wait", 512'(cmp_start), 512'(0));
                chk("req_ready_busy", 512'(req_ready), 512'(0));
            end
            if (k == CMP_LAT + 1) begin
                chk("out_valid_early", 512'(out_valid), 512'(0));
                chk("err_at_capture", 512'(err), 512'(flag == 2'b11));
            end
            if (k == CMP_LAT + 2)
                chk("out_valid_first", 512'(out_valid), 512'(1));
        end
        if (stall > 0) begin
            held_line = out_line;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_line", out_line, held_line);
                chk("stall_last", 512'(out_last), 512'(0));
                chk("stall_valid", 512'(out_valid), 512'(1));
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
        end
        t = 0;
        while (!(out_valid && out_ready && out_last) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("last_timeout", 512'(1), 512'(0));
        req_valid = 2'b00;
        @(negedge clk);
        chk("idle_after", 512'(busy), 512'(0));
        chk("hold_stable", 512'(cmp_pixels == pix), 512'(1));
        chk("err_count", 512'(err_cnt - errs0), 512'(flag == 2'b11));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        types::pixels_t p0, p1, pab;
        p0  = {32{32'h0102_0304}};
        p1  = {32{32'hF0E0_D0C0}};
        pab = '0;
        pab.r_channel[0]  = 8'hAB;
        pab.a_channel[31] = 8'h5C;

        rst = 1'b1; req_valid = 2'b00; req_pixels0 = '0; req_pixels1 = '0;
        cmp_lines = '0; cmp_flag = 2'b00; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_cmp_start", 512'(cmp_start), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        chk("rst_out_meta", 512'({out_last, out_flag, out_src}), 512'(0));
        chk("rst_req_ready", 512'(req_ready), 512'(0));
        chk("rst_cmp_pixels", 512'(cmp_pixels == '0), 512'(1));
        rst = 1'b0;
        @(negedge clk);

        run_block(2'b11, 1'b0, 2'b01, {16{32'hA0A0_0001}}, {16{32'hA1A1_0002}}, p0, p1, 0);
        run_block(2'b11, 1'b1, 2'b01, {16{32'hB0B0_0003}}, {16{32'hB1B1_0004}}, p0, p1, 0);
        run_block(2'b10, 1'b1, 2'b00, {16{32'hDEAD_BEEF}}, {16{32'hCAFE_F00D}}, p0, pab, 0);
        run_block(2'b01, 1'b0, 2'b10, {16{32'hC0C0_0005}}, {16{32'hC1C1_0006}}, p1, p0, 5);
        run_block(2'b11, 1'b1, 2'b11, {16{32'hD0D0_0007}}, {16{32'hD1D1_0008}}, p0, p1, 0);
        run_block(2'b01, 1'b0, 2'b01, {16{32'hE0E0_0009}}, {16{32'hE1E1_000A}}, p0, p1, 0);

        // Block dropped by reset mid-WAIT; without the reset the pointer would favour requester 1.
        req_valid = 2'b01; cmp_flag = 2'b01; req_pixels0 = p1;
        #1 chk("drop_grant", 512'(req_ready), 512'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("drop_busy", 512'(busy), 512'(0));
        chk("drop_out_valid", 512'(out_valid), 512'(0));
        chk("drop_cmp_pixels", 512'(cmp_pixels == '0), 512'(1));
        rst = 1'b0;
        #1 chk("drop_prio", 512'(req_ready), 512'(1));
        req_valid = 2'b00;
        repeat (CMP_LAT + 4) @(negedge clk);

        run_block(2'b11, 1'b0, 2'b10, {16{32'h1111_2222}}, {16{32'h3333_4444}}, p1, p0, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 512'(sb.size()), 512'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
